ddr_iod_tap_ctrl: RTL and testbench
===================================

Name: ddr_iod_tap_ctrl

Overview:
- Per-lane delay-line sequencer driving the dynamic delay controls (MOVE/DIRECTION/LOAD) of one DDR3 address/command IOD lane, e.g. CAS_N. Sits directly upstream of the lane IOD wrapper.
- Converts an absolute tap request from the training/calibration FSM into a paced series of single-tap MOVE pulses.
- Tracks the current tap and monitors the lane's out-of-range flag.

Parameters:
- TAP_W, 8, width of tap values.
- MAX_TAP, 127, highest legal tap; requests above it are clamped.
- INIT_TAP, 1, tap value after a LOAD; equals the IOD TX delay preset.
- MOVE_GAP, 3, idle cycles after each MOVE pulse before the next MOVE or completion; range 1..15.
- LOAD_WAIT, 4, cycles waited after the LOAD pulse; range 1..15.

Ports:
- FAB_CLK  in  1  fabric clock; same clock as the IOD TX_CLK.
- SYNC_RST  in  1  synchronous active-high reset.
- REQ_VALID  in  1  tap request valid.
- REQ_READY  out  1  controller idle; request accepted when VALID&READY.
- REQ_LOAD  in  1  request is a reload to INIT_TAP; REQ_TAP is ignored.
- REQ_TAP  in  TAP_W  requested absolute tap.
- DONE  out  1  one-cycle pulse when a request completes.
- DONE_ERR  out  1  valid with DONE; request aborted on out-of-range.
- CUR_TAP  out  TAP_W  current tap count.
- ERR_RANGE  out  1  sticky out-of-range error.
- ERR_CLR  in  1  clears ERR_RANGE.
- DELAY_LINE_MOVE_0  out  1  one-cycle tap step pulse to the IOD.
- DELAY_LINE_DIRECTION_0  out  1  step direction to the IOD; 1 = increase delay.
- DELAY_LINE_LOAD_0  out  1  one-cycle preset load pulse to the IOD.
- DELAY_LINE_OUT_OF_RANGE_0  in  1  from the IOD; delay line at its limit.

Behaviour:
Clocking and reset:
- Single clock FAB_CLK. Reset is synchronous, active-high on SYNC_RST; all state updates on the rising edge.
- Reset values: MOVE=0, LOAD=0, DIRECTION=0, REQ_READY=0, DONE=0, DONE_ERR=0, ERR_RANGE=0, CUR_TAP=INIT_TAP, state=LOAD.
- After reset releases, an automatic load runs: LOAD is high in the first cycle after release.
- Reset during any state aborts at that edge. MOVE and LOAD go low; no DONE is issued.

States:
- IDLE: REQ_READY=1. On accept:
  - REQ_LOAD=1 -> LOAD. REQ_LOAD takes priority over REQ_TAP.
  - Otherwise latch tgt=min(REQ_TAP, MAX_TAP).
  - tgt==CUR_TAP -> CMPL. No MOVE is issued.
  - tgt!=CUR_TAP -> DIR. DIRECTION <= (tgt>CUR_TAP).
- DIR: one cycle. Guarantees DIRECTION is stable one cycle before MOVE. -> STEP.
- STEP: MOVE=1 for exactly one cycle. CUR_TAP +/-1 at the end of the cycle. -> GAP.
- GAP: count MOVE_GAP cycles. On the last cycle, sample OUT_OF_RANGE:
  - If set: undo the last CUR_TAP step, set ERR_RANGE, err=1 -> CMPL.
  - Else if CUR_TAP==tgt -> CMPL.
  - Else -> STEP.
- LOAD: LOAD=1 for one cycle. CUR_TAP <= INIT_TAP. -> LWAIT.
- LWAIT: LOAD_WAIT cycles -> CMPL.
- CMPL: DONE=1, DONE_ERR=err; clear err -> IDLE.

Outputs and signal rules:
- REQ_READY=1 only in IDLE; REQ_VALID outside IDLE is ignored.
- DIRECTION holds its value except on accept in IDLE.
- MOVE and LOAD are never high together; neither is ever high two consecutive cycles.
- CUR_TAP never wraps. It stays in 0..MAX_TAP; a step that would leave this range ends the request with DONE_ERR=1.
- ERR_RANGE is set by an out-of-range abort. ERR_CLR clears it; set wins if both happen in the same cycle.
- MOVE pulse rate: one per (MOVE_GAP+1) cycles.
- Latency accept->DONE for a move of N taps (N>0): 1+N*(MOVE_GAP+1)+1 cycles (DIR cycle, N step+gap periods, CMPL cycle).
- Latency for N=0: 1 cycle. Latency for a load: 1+LOAD_WAIT+1 cycles.

Decomposition:
- Shared package ddr_phy_pkg: state enum tap_state_t (IDLE, DIR, STEP, GAP, LOAD, LWAIT, CMPL) and the DIR_INC=1 / DIR_DEC=0 constants.
- Top-level parameters carry the tap limits.
- One natural sub-module: ddr_gap_timer, a loadable down-counter with a zero flag, shared by GAP and LWAIT.

Test Plan:
- Reset release -> LOAD high in cycle 1, DONE in cycle 6 (defaults), CUR_TAP=1, REQ_READY=1, no MOVE pulses.
- From tap 1, request 5 -> DIRECTION=1 one cycle before the first MOVE; 4 MOVE pulses 4 cycles apart; DONE 18 cycles after accept; CUR_TAP=5, DONE_ERR=0.
- From tap 5, request 2 -> DIRECTION=0, 3 MOVE pulses, CUR_TAP=2. Then request 2 -> DONE next cycle, no MOVE.
- Request 200 from tap 120 -> clamped to 127; 7 MOVE pulses; CUR_TAP=127.
- From tap 10, request 20; OUT_OF_RANGE forced high after the 3rd MOVE -> abort, CUR_TAP=12, DONE with DONE_ERR=1, ERR_RANGE=1. ERR_CLR -> ERR_RANGE=0.
- SYNC_RST asserted in the GAP after the 2nd MOVE -> MOVE and LOAD low at that edge; no DONE; reload sequence follows release.
- REQ_LOAD and REQ_TAP=50 presented together -> LOAD path taken, CUR_TAP=1.

Source files
------------

// File: rtl/ddr_phy_pkg.sv
// Shared types for the DDR PHY address/command lane logic.
//   tap_state_t : sequencer states of the per-lane tap controller
//   DIR_INC/DEC : DIRECTION encoding expected by the IOD (1 = more delay)
//   GAP_CNT_W   : width of the pacing/settle counter (covers 1..15 cycles)
package ddr_phy_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DIR,
        STEP,
        GAP,
        LOAD,
        LWAIT,
        CMPL
    } tap_state_t;

    localparam logic DIR_INC = 1'b1;
    localparam logic DIR_DEC = 1'b0;

    localparam int GAP_CNT_W = 4;

endpackage

// File: rtl/ddr_gap_timer.sv
// Loadable down-counter with a zero flag. Used to pace MOVE pulses and to
// wait out the IOD settle time after a LOAD.
//   clk_i      : clock
//   srst_i     : synchronous active-high reset (counter -> 0)
//   load_i     : load load_val_i this cycle
//   load_val_i : value to load; the counter then reads zero load_val_i
//                cycles later, i.e. zero_o rises in the (load_val_i+1)th
//                cycle after the load cycle
//   zero_o     : counter is at zero
module ddr_gap_timer
    import ddr_phy_pkg::*;
#(
    parameter int CNT_W = GAP_CNT_W
) (
    input  logic             clk_i,
    input  logic             srst_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic             zero_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/ddr_iod_tap_ctrl.sv
// Per-lane delay-line sequencer for one DDR3 address/command IOD lane.
// Turns an absolute tap request into paced single-tap MOVE pulses, tracks
// the current tap and watches the lane's out-of-range flag.
//   FAB_CLK / SYNC_RST            : clock, synchronous active-high reset
//   REQ_VALID/READY/LOAD/TAP      : request handshake from training FSM
//   DONE / DONE_ERR               : completion pulse and abort status
//   CUR_TAP                       : current tap count
//   ERR_RANGE / ERR_CLR           : sticky out-of-range flag and its clear
//   DELAY_LINE_MOVE/DIRECTION/LOAD_0 : dynamic delay controls to the IOD
//   DELAY_LINE_OUT_OF_RANGE_0     : limit flag from the IOD
module ddr_iod_tap_ctrl
    import ddr_phy_pkg::*;
#(
    parameter int TAP_W     = 8,
    parameter int MAX_TAP   = 127,
    parameter int INIT_TAP  = 1,
    parameter int MOVE_GAP  = 3,
    parameter int LOAD_WAIT = 4
) (
    input  logic             FAB_CLK,
    input  logic             SYNC_RST,
    input  logic             REQ_VALID,
    output logic             REQ_READY,
    input  logic             REQ_LOAD,
    input  logic [TAP_W-1:0] REQ_TAP,
    output logic             DONE,
    output logic             DONE_ERR,
    output logic [TAP_W-1:0] CUR_TAP,
    output logic             ERR_RANGE,
    input  logic             ERR_CLR,
    output logic             DELAY_LINE_MOVE_0,
    output logic             DELAY_LINE_DIRECTION_0,
    output logic             DELAY_LINE_LOAD_0,
    input  logic             DELAY_LINE_OUT_OF_RANGE_0
);

    localparam logic [TAP_W-1:0]     MAX_T  = TAP_W'(MAX_TAP);
    localparam logic [TAP_W-1:0]     INIT_T = TAP_W'(INIT_TAP);
    localparam logic [GAP_CNT_W-1:0] GAP_LD = GAP_CNT_W'(MOVE_GAP - 1);
    localparam logic [GAP_CNT_W-1:0] LW_LD  = GAP_CNT_W'(LOAD_WAIT - 1);

    tap_state_t state_q, state_d;
    logic [TAP_W-1:0] cur_tap_q, cur_tap_d;
    logic [TAP_W-1:0] tgt_q, tgt_d;
    logic [TAP_W-1:0] req_tgt;
    logic             dir_q, dir_d;
    logic             err_q, err_d;
    logic             err_range_q, err_range_d;
    logic             tmr_load;
    logic             tmr_zero;
    logic [GAP_CNT_W-1:0] tmr_val;

    assign req_tgt = (REQ_TAP > MAX_T) ? MAX_T : REQ_TAP;

    // The timer is armed in the cycle before the wait state, so the wait
    // state itself lasts exactly MOVE_GAP (or LOAD_WAIT) cycles.
    assign tmr_load = (state_q == STEP) || (state_q == LOAD);
    assign tmr_val  = (state_q == STEP) ? GAP_LD : LW_LD;

    ddr_gap_timer #(
        .CNT_W (GAP_CNT_W)
    ) u_gap_timer (
        .clk_i      (FAB_CLK),
        .srst_i     (SYNC_RST),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .zero_o     (tmr_zero)
    );

    // State and datapath registers
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q     <= LOAD;
            cur_tap_q   <= INIT_T;
            tgt_q       <= INIT_T;
            dir_q       <= DIR_DEC;
            err_q       <= 1'b0;
            err_range_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_tap_q   <= cur_tap_d;
            tgt_q       <= tgt_d;
            dir_q       <= dir_d;
            err_q       <= err_d;
            err_range_q <= err_range_d;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        cur_tap_d   = cur_tap_q;
        tgt_d       = tgt_q;
        dir_d       = dir_q;
        err_d       = err_q;
        // Clear first; an abort below overrides it in the same cycle.
        err_range_d = err_range_q & ~ERR_CLR;
        case (state_q)
            IDLE: begin
                if (REQ_VALID) begin
                    if (REQ_LOAD) begin
                        state_d = LOAD;
                    end else begin
                        tgt_d = req_tgt;
                        if (req_tgt == cur_tap_q) begin
                            state_d = CMPL;
                        end else begin
                            state_d = DIR;
                            dir_d   = (req_tgt > cur_tap_q) ? DIR_INC : DIR_DEC;
                        end
                    end
                end
            end
            DIR: state_d = STEP;
            STEP: begin
                // The target is clamped to 0..MAX_TAP and steps only head
                // towards it, so this never wraps.
                cur_tap_d = (dir_q == DIR_INC) ? cur_tap_q + TAP_W'(1)
                                               : cur_tap_q - TAP_W'(1);
                state_d   = GAP;
            end
            GAP: begin
                if (tmr_zero) begin
                    if (DELAY_LINE_OUT_OF_RANGE_0) begin
                        // The IOD refused the last step; back the count out.
                        cur_tap_d   = (dir_q == DIR_INC) ? cur_tap_q - TAP_W'(1)
                                                         : cur_tap_q + TAP_W'(1);
                        err_d       = 1'b1;
                        err_range_d = 1'b1;
                        state_d     = CMPL;
                    end else if (cur_tap_q == tgt_q) begin
                        state_d = CMPL;
                    end else begin
                        state_d = STEP;
                    end
                end
            end
            LOAD: begin
                cur_tap_d = INIT_T;
                state_d   = LWAIT;
            end
            LWAIT: begin
                if (tmr_zero) begin
                    state_d = CMPL;
                end
            end
            CMPL: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Moore outputs
    always_comb begin
        REQ_READY         = (state_q == IDLE);
        DONE              = (state_q == CMPL);
        DONE_ERR          = (state_q == CMPL) && err_q;
        DELAY_LINE_MOVE_0 = (state_q == STEP);
        // Reset parks the FSM in LOAD; masking with the reset keeps the
        // LOAD pulse quiet while reset is held, so it fires exactly once in
        // the first cycle after release.
        DELAY_LINE_LOAD_0 = (state_q == LOAD) && !SYNC_RST;
    end

    assign CUR_TAP                = cur_tap_q;
    assign ERR_RANGE              = err_range_q;
    assign DELAY_LINE_DIRECTION_0 = dir_q;

endmodule

// File: tb/tb_ddr_iod_tap_ctrl.sv
module tb_ddr_iod_tap_ctrl;

    localparam int GAPC  = 3;   // MOVE_GAP
    localparam int LWC   = 4;   // LOAD_WAIT
    localparam int MAXT  = 127;
    localparam int INITT = 1;

    logic       clk = 1'b0;
    logic       SYNC_RST = 1'b1;
    logic       REQ_VALID = 1'b0;
    logic       REQ_READY;
    logic       REQ_LOAD = 1'b0;
    logic [7:0] REQ_TAP = 8'd0;
    logic       DONE, DONE_ERR;
    logic [7:0] CUR_TAP;
    logic       ERR_RANGE;
    logic       ERR_CLR = 1'b0;
    logic       MOVE, DIRECTION, LOADP;
    logic       OOR = 1'b0;

    ddr_iod_tap_ctrl dut (
        .FAB_CLK                   (clk),
        .SYNC_RST                  (SYNC_RST),
        .REQ_VALID                 (REQ_VALID),
        .REQ_READY                 (REQ_READY),
        .REQ_LOAD                  (REQ_LOAD),
        .REQ_TAP                   (REQ_TAP),
        .DONE                      (DONE),
        .DONE_ERR                  (DONE_ERR),
        .CUR_TAP                   (CUR_TAP),
        .ERR_RANGE                 (ERR_RANGE),
        .ERR_CLR                   (ERR_CLR),
        .DELAY_LINE_MOVE_0         (MOVE),
        .DELAY_LINE_DIRECTION_0    (DIRECTION),
        .DELAY_LINE_LOAD_0         (LOADP),
        .DELAY_LINE_OUT_OF_RANGE_0 (OOR)
    );

    always #5 clk = ~clk;

    // Expected outputs for one clock cycle
    typedef struct {
        logic       ready;
        logic       move;
        logic       load;
        logic       done;
        logic       derr;
        logic       dir;
        logic       erng;
        logic [7:0] tap;
    } exp_t;

    exp_t exp_q[$];

    int  m_tap = INITT;
    bit  m_dir = 1'b0;
    bit  m_err = 1'b0;
    int  push_lim = 1000000;
    bit  chk_en = 1'b0;
    int  n_chk = 0;
    int  n_fail = 0;
    int  cyc = 0;
    int  done_cyc = 0;
    int  acc_cyc = 0;
    int  move_cnt = 0;
    int  mv_base = 0;
    bit  last_derr = 1'b0;

    task automatic chk(input string nm, input int act, input int expv);
        n_chk++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    function automatic exp_t e_idle();
        exp_t e;
        e.ready = 1'b1; e.move = 1'b0; e.load = 1'b0; e.done = 1'b0;
        e.derr  = 1'b0; e.dir = m_dir; e.erng = m_err; e.tap = 8'(m_tap);
        return e;
    endfunction

    function automatic exp_t e_busy();
        exp_t e;
        e = e_idle();
        e.ready = 1'b0;
        return e;
    endfunction

    task automatic push(input exp_t e);
        if (push_lim > 0) begin
            exp_q.push_back(e);
            push_lim--;
        end
    endtask

    // Timeline of a tap move: accept cycle, one DIR cycle, then per tap one
    // MOVE cycle plus GAPC settle cycles, then the DONE cycle. oor_k>0 means
    // the IOD reports out-of-range after the k-th MOVE.
    task automatic model_move(input int req_tap, input int oor_k);
        int   tgt, c, s, n;
        exp_t e;
        tgt = (req_tap > MAXT) ? MAXT : req_tap;
        c   = m_tap;
        push(e_idle());
        if (tgt == c) begin
            e = e_busy(); e.done = 1'b1;
            push(e);
            return;
        end
        m_dir = (tgt > c);
        s = m_dir ? 1 : -1;
        n = m_dir ? tgt - c : c - tgt;
        e = e_busy();
        push(e);
        for (int k = 1; k <= n; k++) begin
            e = e_busy(); e.move = 1'b1; e.tap = 8'(c + (k - 1) * s);
            push(e);
            for (int g = 0; g < GAPC; g++) begin
                e = e_busy(); e.tap = 8'(c + k * s);
                push(e);
            end
            if (k == oor_k) begin
                m_tap = c + (k - 1) * s;
                m_err = 1'b1;
                e = e_busy(); e.done = 1'b1; e.derr = 1'b1; e.erng = 1'b1;
                e.tap = 8'(m_tap);
                push(e);
                return;
            end
        end
        m_tap = tgt;
        e = e_busy(); e.done = 1'b1;
        push(e);
    endtask

    // Timeline of a load: optional accept cycle, LOAD pulse, LWC wait
    // cycles, then DONE with the tap back at INITT.
    task automatic model_load(input bit with_acc);
        exp_t e;
        if (with_acc) push(e_idle());
        e = e_busy(); e.load = 1'b1;
        push(e);
        m_tap = INITT;
        for (int i = 0; i < LWC; i++) push(e_busy());
        e = e_busy(); e.done = 1'b1;
        push(e);
    endtask

    task automatic push_rst();
        exp_t e;
        m_tap = INITT; m_dir = 1'b0; m_err = 1'b0;
        e = e_busy();
        push(e);
    endtask

    task automatic do_compare();
        exp_t e;
        if (!chk_en) return;
        if (exp_q.size() > 0) e = exp_q.pop_front();
        else e = e_idle();
        chk("REQ_READY", int'(REQ_READY), int'(e.ready));
        chk("MOVE", int'(MOVE), int'(e.move));
        chk("LOAD", int'(LOADP), int'(e.load));
        chk("DONE", int'(DONE), int'(e.done));
        chk("DONE_ERR", int'(DONE_ERR), int'(e.derr));
        chk("DIRECTION", int'(DIRECTION), int'(e.dir));
        chk("ERR_RANGE", int'(ERR_RANGE), int'(e.erng));
        chk("CUR_TAP", int'(CUR_TAP), int'(e.tap));
        chk("MOVE_LOAD_excl", int'(MOVE & LOADP), 0);
        if (MOVE) move_cnt++;
        if (DONE) begin
            done_cyc  = cyc;
            last_derr = DONE_ERR;
        end
    endtask

    // Compare at the falling edge, then advance to just after the next
    // rising edge where new inputs are driven.
    task automatic tick();
        @(negedge clk);
        do_compare();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drain();
        int b = 0;
        while (exp_q.size() != 0 && b < 3000) begin
            tick();
            b++;
        end
        if (exp_q.size() != 0) begin
            chk("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
    endtask

    task automatic req(input bit ld, input int tap, input int oor_k, input int trunc);
        acc_cyc  = cyc;
        mv_base  = move_cnt;
        push_lim = (trunc > 0) ? trunc : 1000000;
        if (ld) model_load(1'b1);
        else    model_move(tap, oor_k);
        push_lim = 1000000;
        if (trunc > 0) begin
            push_rst();
            push_rst();
            model_load(1'b0);
        end
        REQ_VALID = 1'b1;
        REQ_LOAD  = ld;
        REQ_TAP   = 8'(tap);
        tick();
        REQ_VALID = 1'b0;
        REQ_LOAD  = 1'b0;
        REQ_TAP   = 8'hA5;
    endtask

    task automatic report(input string nm);
        $display("txn %-10s cur_tap=%0d moves=%0d latency=%0d done_err=%0d err_range=%0d",
                 nm, CUR_TAP, move_cnt - mv_base, done_cyc - acc_cyc, last_derr, ERR_RANGE);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset and automatic reload
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        push_rst();
        model_load(1'b0);
        tick();
        SYNC_RST = 1'b0;
        acc_cyc  = cyc - 1;
        mv_base  = move_cnt;
        drain();
        tick();
        report("reset");
        chk("rst_tap", int'(CUR_TAP), 1);
        chk("rst_lat", done_cyc - acc_cyc, 6);
        chk("rst_moves", move_cnt - mv_base, 0);
        chk("rst_ready", int'(REQ_READY), 1);

        // Up 1 -> 5; a request presented while busy must be ignored
        req(1'b0, 5, 0, 0);
        REQ_VALID = 1'b1; REQ_TAP = 8'd100;
        tick();
        tick();
        REQ_VALID = 1'b0;
        drain();
        report("up5");
        chk("up_tap", int'(CUR_TAP), 5);
        chk("up_lat", done_cyc - acc_cyc, 18);
        chk("up_moves", move_cnt - mv_base, 4);
        chk("up_derr", int'(last_derr), 0);
        chk("up_dir", int'(DIRECTION), 1);

        // Down 5 -> 2
        req(1'b0, 2, 0, 0);
        drain();
        report("down2");
        chk("down_tap", int'(CUR_TAP), 2);
        chk("down_moves", move_cnt - mv_base, 3);
        chk("down_dir", int'(DIRECTION), 0);

        // Same tap: immediate completion
        req(1'b0, 2, 0, 0);
        drain();
        report("same2");
        chk("same_lat", done_cyc - acc_cyc, 1);
        chk("same_moves", move_cnt - mv_base, 0);

        // Clamp: 120 then 200 -> 127
        req(1'b0, 120, 0, 0);
        drain();
        report("up120");
        req(1'b0, 200, 0, 0);
        drain();
        report("clamp200");
        chk("clamp_tap", int'(CUR_TAP), 127);
        chk("clamp_moves", move_cnt - mv_base, 7);

        // Out-of-range abort from 10 towards 20 after the 3rd MOVE
        req(1'b0, 10, 0, 0);
        drain();
        report("down10");
        req(1'b0, 20, 3, 0);
        repeat (10) tick();
        OOR = 1'b1;
        repeat (4) tick();
        OOR = 1'b0;
        drain();
        report("oor");
        chk("oor_tap", int'(CUR_TAP), 12);
        chk("oor_derr", int'(last_derr), 1);
        chk("oor_erng", int'(ERR_RANGE), 1);
        chk("oor_moves", move_cnt - mv_base, 3);

        // Clear the sticky error
        ERR_CLR = 1'b1;
        push(e_idle());
        m_err = 1'b0;
        tick();
        ERR_CLR = 1'b0;
        tick();
        chk("clr_erng", int'(ERR_RANGE), 0);

        // Reset in the GAP after the 2nd MOVE
        req(1'b0, 30, 0, 8);
        repeat (6) tick();
        SYNC_RST = 1'b1;
        tick();
        tick();
        tick();
        SYNC_RST = 1'b0;
        drain();
        report("rst_gap");
        chk("rstgap_tap", int'(CUR_TAP), 1);
        chk("rstgap_moves", move_cnt - mv_base, 2);

        // Load request wins over a simultaneous tap value
        req(1'b0, 3, 0, 0);
        drain();
        report("up3");
        req(1'b1, 50, 0, 0);
        drain();
        report("load");
        chk("load_tap", int'(CUR_TAP), 1);
        chk("load_lat", done_cyc - acc_cyc, 6);
        chk("load_moves", move_cnt - mv_base, 0);

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
